dma_copy: RTL
=============

// Module: dma_copy
// PURPOSE
//  Word-copy DMA engine and bus initiator on the native valid/ready memory bus.
//  The CPU programs it through a responder port; the engine reads a word from SRC, writes it to DST, and repeats LEN times.
//  Its master port feeds a bus arbiter alongside the CPU. Its config port decodes at 0x0500_0000.
// PARAMETERS
//  LEN_W      16   width of the LEN register (max transfer = 2^LEN_W-1 words)
// PORTS
//  clk        in   1      system clock
//  resetn     in   1      reset; synchronous, active-low
//  valid      in   1      config request (already qualified by address select)
//  ready      out  1      config ack, one-cycle pulse
//  wstrb      in   4      config byte strobes; 0 means read
//  addr       in   32     config address; addr[3:2] selects the register
//  wdata      in   32     config write data
//  rdata      out  32     config read data, valid while ready=1
//  m_valid    out  1      master request
//  m_ready    in   1      master ack from fabric
//  m_addr     out  32     master address, word aligned
//  m_wdata    out  32     master write data
//  m_wstrb    out  4      0 for read, 4'hF for write
//  m_rdata    in   32     master read data, sampled when m_ready=1
//  irq        out  1      completion interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: ready=0, rdata=0, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, irq=0. All registers are 0 and the FSM is IDLE.
//  Reset applied mid-transfer drops m_valid on the next edge; no completion is reported.
//  Config port: ready pulses high exactly 1 cycle after valid is sampled high, and never on two consecutive cycles.
//  Register map (addr[3:2]):
//   0 = SRC
//   1 = DST
//   2 = LEN
//   3 = CTRL
//  SRC/DST writes honour byte lanes; bits [1:0] are forced to 0.
//  LEN write honours byte lanes for [LEN_W-1:0].
//  Reads of SRC/DST/LEN return live pointers and the remaining count.
//  Writes to SRC/DST/LEN while busy are acked and ignored.
//  CTRL write, acting only when wstrb[0]=1:
//   bit0 START: ignored while busy.
//   bit1 ABORT: ignored when idle.
//   bit2 DONE: write-1-to-clear.
//   bit3 IE: read/write.
//  CTRL read: {28'b0, IE, DONE, BUSY, 1'b0}.
//  FSM states:
//   IDLE: on START with LEN==0, set DONE with no bus traffic. On START with LEN!=0, go to RD.
//   RD: m_valid=1, m_addr=SRC, m_wstrb=0. On m_ready, latch m_rdata into buf and go to WR.
//   WR: m_valid=1, m_addr=DST, m_wdata=buf, m_wstrb=F. On m_ready: SRC+=4, DST+=4, LEN-=1. Then go to IDLE and set DONE if the new LEN==0 or an abort is pending; otherwise go to RD.
//  Master handshake: once m_valid rises, m_addr/m_wdata/m_wstrb stay stable until the m_ready cycle.
//  m_valid deasserts for at least 1 cycle between beats, so throughput is at most 1 word per 4 cycles.
//  ABORT is latched as pending. The in-flight beat always completes, and an RD beat is followed by its WR.
//  After an abort the engine returns to IDLE with DONE=1, and LEN reports the remaining words.
//  Pointers wrap modulo 2^32 (0xFFFF_FFFC+4 = 0). LEN never underflows.
//  If START and a DONE clear arrive in the same write, DONE is cleared and the transfer starts.
//  If DONE sets in the same cycle a DONE clear is written, set wins.
//  BUSY = (state != IDLE).
// CONFIGURATION
//  DMA_IRQ_EN defined: irq = DONE & IE, a registered level that stays high until DONE is cleared.
//  DMA_IRQ_EN undefined: irq is tied to 0, the IE bit reads 0 and writes to it are ignored. The port list is unchanged.
// STRUCTURE
//  dma_pkg: FSM state encoding (IDLE/RD/WR), register offsets, and CTRL bit indices.
//  Sub-module dma_regs: config responder, register file, START/ABORT/DONE-clear pulse generation.
//  dma_copy contains the FSM, pointers, data buffer and master port.
// TESTING
//  1. SRC=0x100, DST=0x200, LEN=3, START; memory model m_ready after 2 cycles.
//     Expect 3 read/write pairs to 0x100/0x200, 0x104/0x204, 0x108/0x208.
//     Expect DONE=1, LEN=0, SRC=0x10C.
//  2. LEN=0, START: no m_valid ever; CTRL reads 0x4 on the next read.
//  3. LEN=10; ABORT written during the 2nd RD beat.
//     Expect the 2nd WR to complete, then IDLE with LEN=8, DONE=1, BUSY=0.
//  4. Second START and a write DST=0xDEAD while busy: both ignored, and the transfer result matches scenario 1.
//  5. m_ready held off 20 cycles: m_addr/m_wstrb/m_wdata stay stable throughout. Then SRC=0xFFFF_FFFC, LEN=2: second read goes to 0x0.
//  6. resetn low mid-WR: m_valid=0 and all registers read 0 after release.
//     With DMA_IRQ_EN and IE=1: irq rises 1 cycle after DONE sets and falls after a DONE write-1-to-clear.

Source files
------------

// File: rtl/dma_pkg.sv
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared definitions for the word-copy DMA engine: FSM state
//                encoding, config register offsets, CTRL bit positions,
//                master strobe values and a byte-lane merge helper.
//  Ports       : none (package)
//  Options     : none
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rd   = 2'd1;
    localparam logic [1:0] c_st_wr   = 2'd2;

    // Config register offsets (addr[3:2])
    localparam logic [1:0] c_reg_src  = 2'd0;
    localparam logic [1:0] c_reg_dst  = 2'd1;
    localparam logic [1:0] c_reg_len  = 2'd2;
    localparam logic [1:0] c_reg_ctrl = 2'd3;

    // CTRL bit positions. Bit 1 is ABORT on write and BUSY on read.
    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_abort = 1;
    localparam int c_ctrl_busy  = 1;
    localparam int c_ctrl_done  = 2;
    localparam int c_ctrl_ie    = 3;

    // Master strobe values
    localparam logic [3:0] c_strb_read = 4'h0;
    localparam logic [3:0] c_strb_word = 4'hF;

    // Replace only the byte lanes selected by strb
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_if.sv
// ============================================================================
//  Module      : dma_if
//  Description : Native valid/ready memory bus. Used both for the CPU config
//                port (DMA is the slave) and the DMA master port.
//  Signals     : valid  - request from master
//                ready  - one-cycle acknowledge from slave
//                addr   - byte address (word aligned on the master side)
//                wdata  - write data
//                wstrb  - byte strobes, 0 means read
//                rdata  - read data, valid while ready=1
//  Options     : none
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

`default_nettype wire

// File: rtl/dma_regs.sv
// ============================================================================
//  Module      : dma_regs
//  Description : Config responder for the DMA engine. Acks each request one
//                cycle after it is sampled, decodes register writes into
//                enables/pulses, holds DONE and IE, and muxes read data.
//  Ports       : clk, resetn    - clock, synchronous active-low reset
//                cfg            - config bus (slave side)
//                busy           - engine is not idle
//                src, dst, len  - live pointer/count values for reads
//                done_set       - engine finished (or LEN==0 start)
//                src_we/dst_we/len_we - pointer/count write enables (idle only)
//                start, abort   - single-cycle command pulses
//                irq            - completion interrupt
//  Options     : DMA_IRQ_EN - enables the IE bit and the registered irq output;
//                otherwise IE reads 0 and irq is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_regs
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    dma_if.slave             cfg,
    input  logic             busy,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic             done_set,
    output logic             src_we,
    output logic             dst_we,
    output logic             len_we,
    output logic             start,
    output logic             abort,
    output logic             irq
);

    logic        w_access;
    logic        w_write;
    logic [1:0]  w_sel;
    logic        w_ctrl_we;
    logic        w_done_clr;
    logic        w_ie;
    logic [31:0] w_rd_mux;
    logic        r_done;

    // A request is taken only when ready is low, so ready can never pulse
    // on two consecutive cycles even if valid stays high.
    assign w_access   = cfg.valid && !cfg.ready;
    assign w_write    = w_access && (cfg.wstrb != 4'h0);
    assign w_sel      = cfg.addr[3:2];
    assign w_ctrl_we  = w_write && (w_sel == c_reg_ctrl) && cfg.wstrb[0];

    assign src_we     = w_write && (w_sel == c_reg_src) && !busy;
    assign dst_we     = w_write && (w_sel == c_reg_dst) && !busy;
    assign len_we     = w_write && (w_sel == c_reg_len) && !busy;
    assign start      = w_ctrl_we && cfg.wdata[c_ctrl_start] && !busy;
    assign abort      = w_ctrl_we && cfg.wdata[c_ctrl_abort] && busy;
    assign w_done_clr = w_ctrl_we && cfg.wdata[c_ctrl_done];

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_sel)
            c_reg_src: w_rd_mux = src;
            c_reg_dst: w_rd_mux = dst;
            c_reg_len: w_rd_mux = 32'(len);
            default:   w_rd_mux = {28'd0, w_ie, r_done, busy, 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg.ready <= 1'b0;
            cfg.rdata <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            cfg.ready <= w_access;
            cfg.rdata <= w_access ? w_rd_mux : 32'd0;
            // A completion in the same cycle as a clear must not be lost
            if (done_set)
                r_done <= 1'b1;
            else if (w_done_clr)
                r_done <= 1'b0;
        end
    end

`ifdef DMA_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_ctrl_we) r_ie <= cfg.wdata[c_ctrl_ie];
            r_irq <= r_done & r_ie;
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    logic unused_ie_bit;
    assign unused_ie_bit = cfg.wdata[c_ctrl_ie];
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    // Only addr[3:2] is decoded; the fabric has already qualified the select
    logic unused_cfg;
    assign unused_cfg = &{1'b0, cfg.addr[31:4], cfg.addr[1:0], cfg.wdata[31:4]};

endmodule

`default_nettype wire

// File: rtl/dma_copy.sv
// ============================================================================
//  Module      : dma_copy
//  Description : Word-copy DMA engine. Reads a word from SRC, writes it to
//                DST, advances both pointers and counts LEN down to zero.
//                Programmed through the config port at 0x0500_0000.
//  Ports       : clk, resetn - clock, synchronous active-low reset
//                cfg         - config bus (slave side)
//                mem         - memory bus master towards the arbiter
//                irq         - completion interrupt
//  Options     : DMA_IRQ_EN - irq = DONE & IE (registered); otherwise irq = 0
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_copy
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic clk,
    input  logic resetn,
    dma_if.slave  cfg,
    dma_if.master mem,
    output logic irq
);

    logic [1:0]       r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_buf;
    logic             r_abort_pend;

    logic             w_busy;
    logic             w_src_we;
    logic             w_dst_we;
    logic             w_len_we;
    logic             w_start;
    logic             w_abort;
    logic             w_done_set;
    logic             w_beat_done;
    logic             w_last;
    logic [LEN_W-1:0] w_len_dec;

    assign w_busy      = (r_state != c_st_idle);
    assign w_beat_done = mem.valid && mem.ready;
    assign w_len_dec   = (r_len == '0) ? '0 : r_len - 1'b1;
    // An abort arriving in the final WR cycle still ends the transfer there
    assign w_last      = (w_len_dec == '0) || r_abort_pend || w_abort;
    assign w_done_set  = ((r_state == c_st_idle) && w_start && (r_len == '0)) ||
                         ((r_state == c_st_wr) && w_beat_done && w_last);

    dma_regs #(
        .LEN_W (LEN_W)
    ) u_regs (
        .clk      (clk),
        .resetn   (resetn),
        .cfg      (cfg),
        .busy     (w_busy),
        .src      (r_src),
        .dst      (r_dst),
        .len      (r_len),
        .done_set (w_done_set),
        .src_we   (w_src_we),
        .dst_we   (w_dst_we),
        .len_we   (w_len_we),
        .start    (w_start),
        .abort    (w_abort),
        .irq      (irq)
    );

    // Each beat raises valid from a low state and drops it right after the
    // ack, which leaves a one-cycle gap between beats and keeps addr/data
    // frozen for as long as valid is high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= c_st_idle;
            r_src        <= 32'd0;
            r_dst        <= 32'd0;
            r_len        <= '0;
            r_buf        <= 32'd0;
            r_abort_pend <= 1'b0;
            mem.valid    <= 1'b0;
            mem.addr     <= 32'd0;
            mem.wdata    <= 32'd0;
            mem.wstrb    <= c_strb_read;
        end else begin
            // Config writes are only enabled while idle, so they never
            // collide with the pointer updates below.
            if (w_src_we) r_src <= byte_merge(r_src, cfg.wdata, cfg.wstrb) & ~32'd3;
            if (w_dst_we) r_dst <= byte_merge(r_dst, cfg.wdata, cfg.wstrb) & ~32'd3;
            if (w_len_we) r_len <= LEN_W'(byte_merge(32'(r_len), cfg.wdata, cfg.wstrb));
            if (w_abort)  r_abort_pend <= 1'b1;

            case (r_state)
                c_st_idle: begin
                    r_abort_pend <= 1'b0;
                    if (w_start && (r_len != '0)) r_state <= c_st_rd;
                end
                c_st_rd: begin
                    if (!mem.valid) begin
                        mem.valid <= 1'b1;
                        mem.addr  <= r_src;
                        mem.wstrb <= c_strb_read;
                    end else if (mem.ready) begin
                        mem.valid <= 1'b0;
                        r_buf     <= mem.rdata;
                        r_state   <= c_st_wr;
                    end
                end
                c_st_wr: begin
                    if (!mem.valid) begin
                        mem.valid <= 1'b1;
                        mem.addr  <= r_dst;
                        mem.wdata <= r_buf;
                        mem.wstrb <= c_strb_word;
                    end else if (mem.ready) begin
                        mem.valid <= 1'b0;
                        r_src     <= r_src + 32'd4;
                        r_dst     <= r_dst + 32'd4;
                        r_len     <= w_len_dec;
                        r_state   <= w_last ? c_st_idle : c_st_rd;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule

`default_nettype wire
